hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. The forwarding unit resolves operand hazards by bypassing; this block handles the hazards bypassing cannot fix. It stalls for load-use hazards and for branches resolved in ID, flushes IF/ID on taken branches and jumps, and freezes the whole pipeline while data memory is not ready. It sits beside the ID stage and drives the write enables of PC and every pipeline register.

---
 rtl/mips_pkg.sv | 14 +
 rtl/hazard_detect.sv | 41 ++++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: hazard FSM states,
// register-index width and the NOP instruction encoding.
package mips_pkg;

    localparam int REG_W = 5;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational detection of hazards that forwarding cannot resolve:
// load-use, ALU result feeding an ID branch, and load feeding an ID branch.
module hazard_detect
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] IFID_RegRs,
    input  logic [REG_W-1:0] IFID_RegRt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsBranch,
    input  logic             IDEX_RegWrite,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_RegRd,
    input  logic             EXMEM_MemRead,
    input  logic [REG_W-1:0] EXMEM_RegRd,
    output logic             lu,
    output logic             ba,
    output logic             bl
);

    logic [REG_W-1:0] dst [2];
    logic [1:0]       match;

    assign dst[0] = IDEX_RegRd;
    assign dst[1] = EXMEM_RegRd;

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_match
            assign match[gi] = (dst[gi] != '0) &&
                               ((ID_UsesRs && (dst[gi] == IFID_RegRs)) ||
                                (ID_UsesRt && (dst[gi] == IFID_RegRt)));
        end
    endgenerate

    assign lu = IDEX_MemRead && match[0];
    assign ba = ID_IsBranch && IDEX_RegWrite && !IDEX_MemRead && match[0];
    assign bl = ID_IsBranch && EXMEM_MemRead && match[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and memory freezes for the
// 5-stage core, driving PC and pipeline-register write enables.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IFID_RegRs,
    input  logic [REG_W-1:0] IFID_RegRt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsBranch,
    input  logic             BranchTaken,
    input  logic             JUMP,
    input  logic             IDEX_RegWrite,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_RegRd,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemWrite,
    input  logic [REG_W-1:0] EXMEM_RegRd,
    input  logic             DMemReady,
    output logic             PCWr,
    output logic             IFID_Wr,
    output logic             IDEX_Wr,
    output logic             EXMEM_Wr,
    output logic             MEMWB_Wr,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int TC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(MEM_TIMEOUT - 1);

    hz_state_t        state_reg, saved_reg, eff_state;
    logic             bc_reg;
    logic [TC_W-1:0]  tc_reg;
    logic             memerr_reg;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    logic             lu, ba, bl, mw, stall, flush;

    hazard_detect u_detect (
        .IFID_RegRs    (IFID_RegRs),
        .IFID_RegRt    (IFID_RegRt),
        .ID_UsesRs     (ID_UsesRs),
        .ID_UsesRt     (ID_UsesRt),
        .ID_IsBranch   (ID_IsBranch),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_RegRd    (IDEX_RegRd),
        .EXMEM_MemRead (EXMEM_MemRead),
        .EXMEM_RegRd   (EXMEM_RegRd),
        .lu            (lu),
        .ba            (ba),
        .bl            (bl)
    );

    // On the unfreeze cycle the saved state decides, so a pending bubble or
    // hazard is handled in that same cycle.
    always_comb begin
        mw        = (EXMEM_MemRead || EXMEM_MemWrite) && !DMemReady;
        eff_state = (state_reg == FREEZE) ? saved_reg : state_reg;
        stall     = !mw && ((eff_state == STALL) || lu || ba || bl);
        flush     = !mw && !stall && ((ID_IsBranch && BranchTaken) || JUMP);
    end

    always_comb begin
        PCWr        = 1'b1;
        IFID_Wr     = 1'b1;
        IDEX_Wr     = 1'b1;
        EXMEM_Wr    = 1'b1;
        MEMWB_Wr    = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        if (rst) begin
            {PCWr, IFID_Wr, IDEX_Wr, EXMEM_Wr, MEMWB_Wr} = '0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
        end else if (mw) begin
            {PCWr, IFID_Wr, IDEX_Wr, EXMEM_Wr, MEMWB_Wr} = '0;
        end else if (stall) begin
            PCWr        = 1'b0;
            IFID_Wr     = 1'b0;
            IDEX_Bubble = 1'b1;
        end else begin
            IFID_Flush  = flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            saved_reg     <= RUN;
            bc_reg        <= 1'b0;
            tc_reg        <= '0;
            memerr_reg    <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (mw) begin
            if (state_reg != FREEZE) begin
                saved_reg <= state_reg;
            end
            state_reg <= FREEZE;
            if (tc_reg == TC_LAST) begin
                memerr_reg <= 1'b1;
            end else begin
                tc_reg <= tc_reg + 1'b1;
            end
        end else begin
            tc_reg <= '0;
            if (eff_state == STALL) begin
                if (bc_reg == 1'b0) begin
                    state_reg <= RUN;
                end else begin
                    bc_reg    <= bc_reg - 1'b1;
                    state_reg <= STALL;
                end
            end else if (lu && ID_IsBranch) begin
                // A load feeding an ID branch needs a second bubble.
                state_reg <= STALL;
                bc_reg    <= 1'b0;
            end else begin
                state_reg <= RUN;
            end
            if (stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (flush && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign MemErr   = memerr_reg;
    assign StallCnt = stall_cnt_reg;
    assign FlushCnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan steps followed by
// random traffic, all compared against a cycle-level reference model.
module tb_hazard_ctrl;
    import mips_pkg::*;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [4:0]       IFID_RegRs, IFID_RegRt, IDEX_RegRd, EXMEM_RegRd;
    logic             ID_UsesRs, ID_UsesRt, ID_IsBranch, BranchTaken, JUMP;
    logic             IDEX_RegWrite, IDEX_MemRead, EXMEM_MemRead, EXMEM_MemWrite, DMemReady;
    logic             PCWr, IFID_Wr, IDEX_Wr, EXMEM_Wr, MEMWB_Wr, IFID_Flush, IDEX_Bubble, MemErr;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .BranchTaken(BranchTaken), .JUMP(JUMP),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegRd(IDEX_RegRd),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite), .EXMEM_RegRd(EXMEM_RegRd),
        .DMemReady(DMemReady),
        .PCWr(PCWr), .IFID_Wr(IFID_Wr), .IDEX_Wr(IDEX_Wr), .EXMEM_Wr(EXMEM_Wr), .MEMWB_Wr(MEMWB_Wr),
        .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble), .MemErr(MemErr),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bubbles still owed, consecutive freeze cycles, flags.
    int               m_pend = 0;
    int               m_frz  = 0;
    logic             m_err  = 1'b0;
    logic [CNT_W-1:0] m_scnt = '0;
    logic [CNT_W-1:0] m_fcnt = '0;
    logic [CNT_W-1:0] scnt_mark;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic srcmatch(input logic [4:0] r);
        return (r != 0) && ((ID_UsesRs && r == IFID_RegRs) || (ID_UsesRt && r == IFID_RegRt));
    endfunction

    task automatic idle();
        rst = 0; IFID_RegRs = 0; IFID_RegRt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
        ID_IsBranch = 0; BranchTaken = 0; JUMP = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0;
        IDEX_RegRd = 0; EXMEM_MemRead = 0; EXMEM_MemWrite = 0; EXMEM_RegRd = 0; DMemReady = 1;
    endtask

    // Called at posedge+1 with inputs applied; checks at negedge and after the edge.
    task automatic step(input string tag);
        logic [6:0] exp_o, obs_o;
        logic       lu, ba, bl, mw;
        #4;
        lu = IDEX_MemRead && srcmatch(IDEX_RegRd);
        ba = ID_IsBranch && IDEX_RegWrite && !IDEX_MemRead && srcmatch(IDEX_RegRd);
        bl = ID_IsBranch && EXMEM_MemRead && srcmatch(EXMEM_RegRd);
        mw = (EXMEM_MemRead || EXMEM_MemWrite) && !DMemReady;
        obs_o = {PCWr, IFID_Wr, IDEX_Wr, EXMEM_Wr, MEMWB_Wr, IFID_Flush, IDEX_Bubble};
        if (rst) begin
            exp_o = 7'b0000011;
            m_pend = 0; m_frz = 0; m_err = 0; m_scnt = '0; m_fcnt = '0;
        end else if (mw) begin
            exp_o = 7'b0000000;
            m_frz++;
            if (m_frz >= MEM_TIMEOUT) m_err = 1'b1;
        end else begin
            m_frz = 0;
            if (m_pend > 0 || lu || ba || bl) begin
                exp_o = 7'b0011101;
                if (m_pend > 0) m_pend--;
                else if (lu && ID_IsBranch) m_pend = 1;
                if (m_scnt != '1) m_scnt++;
            end else if ((ID_IsBranch && BranchTaken) || JUMP) begin
                exp_o = 7'b1111110;
                if (m_fcnt != '1) m_fcnt++;
            end else begin
                exp_o = 7'b1111100;
            end
        end
        check({tag, "_out"}, 64'(obs_o), 64'(exp_o));
        @(posedge clk); #1;
        check({tag, "_scnt"}, 64'(StallCnt), 64'(m_scnt));
        check({tag, "_fcnt"}, 64'(FlushCnt), 64'(m_fcnt));
        check({tag, "_err"}, 64'(MemErr), 64'(m_err));
        $display("step %s out=%b scnt=%0d fcnt=%0d err=%b", tag, obs_o, StallCnt, FlushCnt, MemErr);
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;
        step("reset0");
        step("reset1");
        idle();
        step("idle");

        // lw $2 then add reading $2: one bubble
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_RegRd = 2; IFID_RegRs = 2; ID_UsesRs = 1;
        step("lu_bubble");
        check("lu_scnt1", 64'(StallCnt), 64'd1);
        idle(); step("lu_after");
        check("lu_after_pcwr", 64'(PCWr), 64'd1);

        // lw $3 then beq on $3: two bubbles, then taken branch flushes
        IDEX_MemRead = 1; IDEX_RegWrite = 1; IDEX_RegRd = 3; IFID_RegRt = 3; ID_UsesRt = 1; ID_IsBranch = 1;
        step("lb_b1");
        IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_RegRd = 0; EXMEM_MemRead = 1; EXMEM_RegRd = 3;
        BranchTaken = 1;
        step("lb_b2");
        EXMEM_MemRead = 0; EXMEM_RegRd = 0;
        step("lb_flush");
        check("lb_fcnt1", 64'(FlushCnt), 64'd1);
        check("lb_scnt3", 64'(StallCnt), 64'd3);

        // jumps with no hazard, including a $0 destination load
        idle(); JUMP = 1; step("jump");
        IDEX_MemRead = 1; IDEX_RegRd = 0; IFID_RegRs = 0; ID_UsesRs = 1; step("jump_r0");
        check("jump_fcnt3", 64'(FlushCnt), 64'd3);

        // freeze for 5 cycles in the middle of the two-bubble sequence
        idle(); scnt_mark = StallCnt;
        IDEX_MemRead = 1; IDEX_RegRd = 4; IFID_RegRs = 4; ID_UsesRs = 1; ID_IsBranch = 1;
        step("fz_b1");
        IDEX_MemRead = 0; IDEX_RegRd = 0; EXMEM_MemRead = 1; DMemReady = 0;
        for (int i = 0; i < 5; i++) step("fz_hold");
        DMemReady = 1; EXMEM_MemRead = 0;
        step("fz_b2");
        idle(); step("fz_done");
        check("fz_two_bubbles", 64'(StallCnt - scnt_mark), 64'd2);

        // memory timeout: MemErr after the 16th frozen cycle, sticky until rst
        EXMEM_MemWrite = 1; DMemReady = 0;
        for (int i = 0; i < MEM_TIMEOUT + 3; i++) step("to_hold");
        idle(); step("to_release"); step("to_sticky");
        check("to_sticky_err", 64'(MemErr), 64'd1);

        // rst while in STALL
        IDEX_MemRead = 1; IDEX_RegRd = 5; IFID_RegRt = 5; ID_UsesRt = 1; ID_IsBranch = 1;
        step("rs_b1");
        idle(); rst = 1; step("rs_rst");
        idle(); step("rs_run");
        check("rs_pcwr", 64'(PCWr), 64'd1);
        check("rs_scnt0", 64'(StallCnt), 64'd0);

        // random traffic on a small register set so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            rst            = ($urandom_range(0, 49) == 0);
            IFID_RegRs     = 5'($urandom_range(0, 3));
            IFID_RegRt     = 5'($urandom_range(0, 3));
            ID_UsesRs      = 1'($urandom);
            ID_UsesRt      = 1'($urandom);
            ID_IsBranch    = 1'($urandom);
            BranchTaken    = 1'($urandom);
            JUMP           = ($urandom_range(0, 5) == 0);
            IDEX_RegWrite  = 1'($urandom);
            IDEX_MemRead   = 1'($urandom);
            IDEX_RegRd     = 5'($urandom_range(0, 3));
            EXMEM_MemRead  = 1'($urandom);
            EXMEM_MemWrite = ($urandom_range(0, 3) == 0);
            EXMEM_RegRd    = 5'($urandom_range(0, 3));
            DMemReady      = ($urandom_range(0, 4) != 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
